// File: rtl/md_unit.sv
// rtl/md_unit.sv - MIPS execute-stage multiply/divide unit owning HI/LO (optional MADD family via MD_UNIT_MADD_EN)
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_start,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] out_hi,
    output logic [31:0] out_lo,
    output logic        out_busy,
    output logic        out_stall
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam logic [4:0] MUL_LAT = 5'(MUL_CYCLES);
    localparam logic [4:0] DIV_LAT = 5'(DIV_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [31:0] temp_hi, temp_hi_n;
    logic [31:0] temp_lo, temp_lo_n;
    logic [31:0] hi_n, lo_n;

    logic        op_ok;
    logic [4:0]  op_lat;
    logic [63:0] op_res;

    // Products: low 64 bits of a sign-extended multiply equal the signed product
    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    assign a_sx   = {{32{in_a[31]}}, in_a};
    assign b_sx   = {{32{in_b[31]}}, in_b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, in_a} * {32'd0, in_b};

    // Divides: signed handled through magnitudes so 0x80000000 / -1 wraps cleanly
    logic        div_zero;
    logic [31:0] den_u;
    logic [31:0] udiv_q, udiv_r;
    logic [31:0] a_mag, b_mag;
    logic [31:0] mag_q, mag_r;
    logic [31:0] sdiv_q, sdiv_r;
    assign div_zero = (in_b == 32'd0);
    assign den_u    = div_zero ? 32'd1 : in_b;
    assign udiv_q   = in_a / den_u;
    assign udiv_r   = in_a % den_u;
    assign a_mag    = in_a[31] ? (32'd0 - in_a) : in_a;
    assign b_mag    = in_b[31] ? (32'd0 - in_b) : den_u;
    assign mag_q    = a_mag / b_mag;
    assign mag_r    = a_mag % b_mag;
    assign sdiv_q   = (in_a[31] ^ in_b[31]) ? (32'd0 - mag_q) : mag_q;
    assign sdiv_r   = in_a[31] ? (32'd0 - mag_r) : mag_r;

`ifdef MD_UNIT_MADD_EN
    // Accumulate against HI/LO as they stand at the accept edge
    logic [63:0] acc;
    assign acc = {out_hi, out_lo};
`endif

    // Decode whether the op occupies the unit, its latency, and its 64-bit result
    always_comb begin
        op_ok  = 1'b0;
        op_lat = MUL_LAT;
        op_res = {out_hi, out_lo};
        case (in_op)
            OP_MULT: begin
                op_ok  = 1'b1;
                op_res = prod_s;
            end
            OP_MULTU: begin
                op_ok  = 1'b1;
                op_res = prod_u;
            end
            OP_DIV: begin
                op_ok  = 1'b1;
                op_lat = DIV_LAT;
                if (!div_zero) op_res = {sdiv_r, sdiv_q};
            end
            OP_DIVU: begin
                op_ok  = 1'b1;
                op_lat = DIV_LAT;
                if (!div_zero) op_res = {udiv_r, udiv_q};
            end
`ifdef MD_UNIT_MADD_EN
            OP_MADD: begin
                op_ok  = 1'b1;
                op_res = acc + prod_s;
            end
            OP_MADDU: begin
                op_ok  = 1'b1;
                op_res = acc + prod_u;
            end
            OP_MSUB: begin
                op_ok  = 1'b1;
                op_res = acc - prod_s;
            end
            OP_MSUBU: begin
                op_ok  = 1'b1;
                op_res = acc - prod_u;
            end
`endif
            default: begin
                op_ok = 1'b0;
            end
        endcase
    end

    // Next-state: accept in IDLE, count down in BUSY, commit HI/LO on the last busy edge
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        temp_hi_n = temp_hi;
        temp_lo_n = temp_lo;
        hi_n      = out_hi;
        lo_n      = out_lo;
        case (state)
            IDLE: begin
                if (in_start) begin
                    if (op_ok) begin
                        state_n   = BUSY;
                        cnt_n     = op_lat;
                        temp_hi_n = op_res[63:32];
                        temp_lo_n = op_res[31:0];
                    end else if (in_op == OP_MTHI) begin
                        hi_n = in_a;
                    end else if (in_op == OP_MTLO) begin
                        lo_n = in_a;
                    end
                end
            end
            BUSY: begin
                cnt_n = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    state_n = IDLE;
                    hi_n    = temp_hi;
                    lo_n    = temp_lo;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and architectural registers; reset aborts any pending result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            temp_hi <= 32'd0;
            temp_lo <= 32'd0;
            out_hi  <= 32'd0;
            out_lo  <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            temp_hi <= temp_hi_n;
            temp_lo <= temp_lo_n;
            out_hi  <= hi_n;
            out_lo  <= lo_n;
        end
    end

    assign out_busy  = (state == BUSY);
    assign out_stall = out_busy | (in_start & op_ok);

endmodule
